// File: rtl/rs485_pkg.sv
// rs485_pkg: shared constants and state encodings for the RS-485 frame responder.
package rs485_pkg;
  localparam logic [7:0] SOF        = 8'h7E;
  localparam logic [7:0] BCAST_ADDR = 8'hFF;
  localparam logic [7:0] STAT_ACK   = 8'h00;
  localparam logic [7:0] STAT_NAK   = 8'h01;
  localparam logic [7:0] REPLY_FLAG = 8'h80;
  typedef enum logic [2:0] {
    S_HUNT, S_ADDR, S_CMD, S_LEN, S_DATA, S_CSUM, S_CHECK, S_REPLY
  } rx_state_t;
  typedef enum logic [1:0] {
    T_IDLE, T_SEND, T_WAIT_LO, T_WAIT_HI
  } tx_state_t;
endpackage

// File: rtl/rs485_reply_tx.sv
// rs485_reply_tx: sequences the 5-byte ACK/NAK reply through the link's tx_cmd/tx_ready handshake.
module rs485_reply_tx
  import rs485_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_cmd,
  input  logic [7:0] i_status,
  input  logic       i_tx_ready,
  output logic       o_tx_cmd,
  output logic [7:0] o_tx_data,
  output logic       o_first,
  output logic       o_done
);
  tx_state_t  r_state, w_next;
  logic [2:0] r_idx;
  logic [7:0] r_addr, r_cmd, r_status;
  logic       w_last;

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= T_IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_idx    <= '0;
      r_addr   <= '0;
      r_cmd    <= '0;
      r_status <= '0;
    end else if (r_state == T_IDLE && i_start) begin
      r_idx    <= '0;
      r_addr   <= i_addr;
      r_cmd    <= i_cmd | REPLY_FLAG;
      r_status <= i_status;
    end else if (r_state == T_WAIT_HI && i_tx_ready) begin
      r_idx    <= r_idx + 3'd1;
    end

  assign w_last = r_idx == 3'd4;

  always_comb begin
    w_next = r_state;
    case (r_state)
      T_IDLE:    if (i_start)     w_next = T_SEND;
      T_SEND:    if (i_tx_ready)  w_next = T_WAIT_LO;
      T_WAIT_LO: if (!i_tx_ready) w_next = T_WAIT_HI;
      T_WAIT_HI: if (i_tx_ready)  w_next = w_last ? T_IDLE : T_SEND;
      default:                    w_next = T_IDLE;
    endcase
  end

  // byte index only moves after the link is idle again, so the data holds through the handshake
  always_comb
    o_tx_data = (r_state == T_IDLE) ? 8'h00 :
                (r_idx == 3'd0)     ? SOF :
                (r_idx == 3'd1)     ? r_addr :
                (r_idx == 3'd2)     ? r_cmd :
                (r_idx == 3'd3)     ? r_status :
                                      r_addr ^ r_cmd ^ r_status;

  assign o_tx_cmd = (r_state == T_SEND) && i_tx_ready;
  assign o_first  = o_tx_cmd && (r_idx == 3'd0);
  assign o_done   = (r_state == T_WAIT_HI) && i_tx_ready && w_last;
endmodule

// File: rtl/rs485_frame_responder.sv
// rs485_frame_responder: parses addressed request frames from the byte link, buffers payloads,
// counts errors and answers addressed frames with an ACK/NAK reply.
module rs485_frame_responder
  import rs485_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  parameter  int TIMEOUT = 50000,
  localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    node_addr,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic          tx_cmd,
  output logic [7:0]    tx_data,
  output logic          r2tdelay_en,
  output logic          frm_valid,
  output logic [7:0]    frm_cmd,
  output logic [7:0]    frm_len,
  input  logic [AW-1:0] pl_raddr,
  output logic [7:0]    pl_rdata,
  output logic [7:0]    err_cnt,
  output logic          busy
);
  rx_state_t     r_state, w_next;
  logic          r_mine, r_bcast, r_good, r_frm_valid;
  logic [7:0]    r_cmd, r_len, r_idx, r_csum, r_frm_cmd, r_frm_len, r_err_cnt;
  logic [TW-1:0] r_to;
  logic [7:0]    r_buf [MAX_LEN];
  logic          w_in_frame, w_timeout, w_too_long, w_accept, w_reply, w_err, w_done;

  assign w_in_frame = r_state inside {S_ADDR, S_CMD, S_LEN, S_DATA, S_CSUM};
  assign w_timeout  = w_in_frame && !rx_ready && (r_to == TW'(TIMEOUT - 1));
  assign w_too_long = (r_state == S_LEN) && rx_ready && (rx_data > 8'(MAX_LEN));
  assign w_accept   = (r_state == S_CSUM) && rx_ready && (r_csum == rx_data) && (r_mine || r_bcast);
  assign w_reply    = (r_state == S_CHECK) && r_mine;
  assign w_err      = w_timeout || w_too_long || ((r_state == S_CHECK) && !r_good && (r_mine || r_bcast));

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= S_HUNT;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HUNT:  if (rx_ready && rx_data == SOF) w_next = S_ADDR;
      S_ADDR:  if (rx_ready) w_next = S_CMD;
      S_CMD:   if (rx_ready) w_next = S_LEN;
      S_LEN:   if (rx_ready) w_next = w_too_long ? S_HUNT : (rx_data == 8'h00) ? S_CSUM : S_DATA;
      S_DATA:  if (rx_ready && r_idx == r_len - 8'd1) w_next = S_CSUM;
      S_CSUM:  if (rx_ready) w_next = S_CHECK;
      S_CHECK: w_next = w_reply ? S_REPLY : S_HUNT;
      S_REPLY: if (w_done) w_next = S_HUNT;
      default: w_next = S_HUNT;
    endcase
    if (w_timeout) w_next = S_HUNT;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_mine      <= 1'b0;
      r_bcast     <= 1'b0;
      r_good      <= 1'b0;
      r_frm_valid <= 1'b0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_frm_cmd   <= '0;
      r_frm_len   <= '0;
      r_err_cnt   <= '0;
      r_to        <= '0;
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
    end else begin
      r_frm_valid <= w_accept;
      r_to        <= (w_in_frame && !rx_ready) ? r_to + TW'(1) : '0;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (rx_ready && r_state == S_ADDR) begin
        r_mine  <= rx_data == node_addr;
        r_bcast <= rx_data == BCAST_ADDR;
        r_csum  <= rx_data;
      end
      if (rx_ready && r_state inside {S_CMD, S_LEN, S_DATA}) r_csum <= r_csum ^ rx_data;
      if (rx_ready && r_state == S_CMD) r_cmd <= rx_data;
      if (rx_ready && r_state == S_LEN) begin
        r_len <= rx_data;
        r_idx <= '0;
      end
      if (rx_ready && r_state == S_DATA) begin
        r_idx <= r_idx + 8'd1;
        if (r_mine || r_bcast) r_buf[r_idx[AW-1:0]] <= rx_data;
      end
      if (rx_ready && r_state == S_CSUM) r_good <= r_csum == rx_data;
      if (w_accept) begin
        r_frm_cmd <= r_cmd;
        r_frm_len <= r_len;
      end
    end

  rs485_reply_tx u_tx (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_reply),
    .i_addr     (node_addr),
    .i_cmd      (r_cmd),
    .i_status   (r_good ? STAT_ACK : STAT_NAK),
    .i_tx_ready (tx_ready),
    .o_tx_cmd   (tx_cmd),
    .o_tx_data  (tx_data),
    .o_first    (r2tdelay_en),
    .o_done     (w_done)
  );

  assign frm_valid = r_frm_valid;
  assign frm_cmd   = r_frm_cmd;
  assign frm_len   = r_frm_len;
  assign pl_rdata  = r_buf[pl_raddr];
  assign err_cnt   = r_err_cnt;
  assign busy      = r_state != S_HUNT;
endmodule

// File: tb/tb_rs485_frame_responder.sv
// tb_rs485_frame_responder: randomized frames against a frame-level reference model of the responder.
module tb_rs485_frame_responder;
  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 40;
  localparam int AW = 3;
  localparam logic [7:0] NODE = 8'h12;

  logic clock = 1'b0, reset = 1'b0, rx_ready = 1'b0, tx_ready = 1'b1;
  logic [7:0] node_addr = NODE, rx_data = 8'h00;
  logic [AW-1:0] pl_raddr = '0;
  logic tx_cmd, r2tdelay_en, frm_valid, busy;
  logic [7:0] tx_data, frm_cmd, frm_len, pl_rdata, err_cnt;

  int total = 0, bad = 0;
  logic [7:0] frm_q[$], tx_q[$];
  logic r2t_q[$];
  int fv_n = 0, hold_viol = 0;
  logic [7:0] last_tx;
  logic [7:0] m_buf [MAX_LEN];
  logic [7:0] m_cmd, m_len;
  int m_err;

  always #5 clock = ~clock;

  rs485_frame_responder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .node_addr(node_addr),
    .rx_ready(rx_ready), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_cmd(tx_cmd), .tx_data(tx_data), .r2tdelay_en(r2tdelay_en),
    .frm_valid(frm_valid), .frm_cmd(frm_cmd), .frm_len(frm_len),
    .pl_raddr(pl_raddr), .pl_rdata(pl_rdata), .err_cnt(err_cnt), .busy(busy)
  );

  always @(negedge clock) begin
    if (tx_cmd) begin
      tx_q.push_back(tx_data);
      r2t_q.push_back(r2tdelay_en);
      last_tx = tx_data;
    end else if (reset && busy && !tx_ready && tx_data !== last_tx) hold_viol++;
    if (frm_valid) fv_n++;
  end

  // link model: accepts a byte at the clock edge, then stays busy for a random time
  initial forever begin
    @(negedge clock);
    if (tx_cmd) begin
      @(posedge clock); #2 tx_ready = 1'b0;
      repeat ($urandom_range(4, 1)) @(posedge clock);
      #2 tx_ready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic send_bytes(input int min_gap, input int max_gap);
    foreach (frm_q[k]) begin
      repeat ($urandom_range(max_gap, min_gap)) begin
        @(negedge clock);
        rx_ready = 1'b0;
      end
      @(negedge clock);
      rx_ready = 1'b1;
      rx_data  = frm_q[k];
    end
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] obs [9];
    string nm [9];
    nm = '{"tx_cmd", "tx_data", "r2tdelay_en", "frm_valid", "frm_cmd", "frm_len", "err_cnt", "busy", "pl_rdata"};
    reset = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clock);
    for (int p = 0; p < 2; p++) begin
      obs = '{8'(tx_cmd), tx_data, 8'(r2tdelay_en), 8'(frm_valid), frm_cmd, frm_len, err_cnt, 8'(busy), pl_rdata};
      for (int i = 0; i < 9; i++) begin
        total++;
        if (obs[i] !== 8'h00) begin
          bad++;
          $display("FAIL reset_%s phase=%0d got=%h want=00", nm[i], p, obs[i]);
        end
      end
      if (p == 0) begin
        reset = 1'b1;
        @(negedge clock);
      end
    end
    foreach (m_buf[k]) m_buf[k] = 8'h00;
    m_cmd = 8'h00;
    m_len = 8'h00;
    m_err = 0;
  endtask

  task automatic test_frames(input int n_rand);
    logic [7:0] a, c, l, cs, x, st;
    logic [7:0] pl [MAX_LEN];
    logic [7:0] er [5];
    logic force_cs, mine, bc, good, e_fv;
    int n;
    for (int i = 0; i < 5 + n_rand; i++) begin
      foreach (pl[k]) pl[k] = 8'($urandom);
      force_cs = 1'b0;
      cs = 8'($urandom);
      c = 8'($urandom);
      case (i)
        0, 1: begin a = NODE; c = 8'h05; l = 8'd2; pl[0] = 8'hAA; pl[1] = 8'h55; force_cs = (i == 1); cs = 8'h00; end
        2: begin a = 8'hFF; c = 8'h03; l = 8'd0; end
        3: begin a = 8'h34; c = 8'h05; l = 8'd1; pl[0] = 8'h7E; end
        4: begin a = NODE; l = 8'(MAX_LEN); end
        default: begin
          n = $urandom_range(3, 0);
          a = (n < 2) ? NODE : (n == 2) ? 8'hFF : 8'($urandom);
          l = 8'($urandom_range(MAX_LEN, 0));
          force_cs = ($urandom_range(3, 0) == 0);
        end
      endcase
      x = a ^ c ^ l;
      for (int k = 0; k < l; k++) x ^= pl[k];
      if (!force_cs) cs = x;
      frm_q = '{8'h7E, a, c, l};
      for (int k = 0; k < l; k++) frm_q.push_back(pl[k]);
      frm_q.push_back(cs);
      mine = (a == NODE);
      bc = (a == 8'hFF);
      good = (cs == x);
      e_fv = good && (mine || bc);
      st = good ? 8'h00 : 8'h01;
      er = '{8'h7E, NODE, c | 8'h80, st, NODE ^ (c | 8'h80) ^ st};
      if (!good && (mine || bc) && m_err < 255) m_err++;
      if (mine || bc) for (int k = 0; k < l; k++) m_buf[k] = pl[k];
      if (e_fv) begin m_cmd = c; m_len = l; end
      tx_q.delete();
      r2t_q.delete();
      fv_n = 0;
      send_bytes(0, (i % 3 == 0) ? 0 : 3);
      total++;
      if (frm_valid !== e_fv) begin bad++; $display("FAIL fv_timing frame=%0d got=%b want=%b", i, frm_valid, e_fv); end
      total++;
      if (tx_cmd !== 1'b0) begin bad++; $display("FAIL tx_in_check frame=%0d got=%b want=0", i, tx_cmd); end
      n = 0;
      while ((busy || !tx_ready) && n < 300) begin @(negedge clock); n++; end
      total++;
      if (n >= 300) begin bad++; $display("FAIL idle_wait frame=%0d got=busy want=idle", i); end
      total++;
      if (fv_n !== int'(e_fv)) begin bad++; $display("FAIL fv_count frame=%0d got=%0d want=%0d", i, fv_n, e_fv); end
      total++;
      if (frm_cmd !== m_cmd || frm_len !== m_len) begin
        bad++;
        $display("FAIL frm_fields frame=%0d got=%h/%h want=%h/%h", i, frm_cmd, frm_len, m_cmd, m_len);
      end
      total++;
      if (tx_q.size() != (mine ? 5 : 0)) begin bad++; $display("FAIL reply_len frame=%0d got=%0d want=%0d", i, tx_q.size(), mine ? 5 : 0); end
      else if (mine) for (int k = 0; k < 5; k++) begin
        total++;
        if (tx_q[k] !== er[k] || r2t_q[k] !== (k == 0)) begin
          bad++;
          $display("FAIL reply_byte frame=%0d idx=%0d got=%h/%b want=%h/%b", i, k, tx_q[k], r2t_q[k], er[k], k == 0);
        end
      end
      total++;
      if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL err_cnt frame=%0d got=%0d want=%0d", i, err_cnt, m_err); end
      for (int k = 0; k < MAX_LEN; k++) begin
        pl_raddr = AW'(k);
        #1;
        total++;
        if (pl_rdata !== m_buf[k]) begin bad++; $display("FAIL payload frame=%0d idx=%0d got=%h want=%h", i, k, pl_rdata, m_buf[k]); end
      end
      total++;
      if (hold_viol != 0) begin bad++; $display("FAIL tx_hold frame=%0d got=%0d want=0", i, hold_viol); end
    end
  endtask

  task automatic test_len_overflow;
    logic [7:0] x;
    int n;
    frm_q = '{8'h7E, NODE, 8'h05, 8'(MAX_LEN + 1)};
    send_bytes(0, 1);
    if (m_err < 255) m_err++;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL overflow_hunt got=%b want=0", busy); end
    total++;
    if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL overflow_err got=%0d want=%0d", err_cnt, m_err); end
    x = NODE ^ 8'h07 ^ 8'h01 ^ 8'h33;
    frm_q = '{8'h7E, NODE, 8'h07, 8'h01, 8'h33, x};
    tx_q.delete();
    r2t_q.delete();
    send_bytes(0, 0);
    total++;
    if (frm_valid !== 1'b1) begin bad++; $display("FAIL overflow_next_fv got=%b want=1", frm_valid); end
    n = 0;
    while ((busy || !tx_ready) && n < 300) begin @(negedge clock); n++; end
    m_cmd = 8'h07; m_len = 8'h01; m_buf[0] = 8'h33;
    total++;
    if (tx_q.size() != 5 || tx_q[2] !== 8'h87 || tx_q[3] !== 8'h00) begin
      bad++;
      $display("FAIL overflow_next_reply got_n=%0d want=5 bytes ending 87 00", tx_q.size());
    end
  endtask

  task automatic test_timeout;
    int n;
    frm_q = '{8'h7E, NODE, 8'h09, 8'h01, 8'h5A, NODE ^ 8'h09 ^ 8'h01 ^ 8'h5A};
    tx_q.delete();
    send_bytes(TIMEOUT - 2, TIMEOUT - 2);
    total++;
    if (frm_valid !== 1'b1) begin bad++; $display("FAIL slow_frame_fv got=%b want=1", frm_valid); end
    n = 0;
    while ((busy || !tx_ready) && n < 300) begin @(negedge clock); n++; end
    m_cmd = 8'h09; m_len = 8'h01; m_buf[0] = 8'h5A;
    total++;
    if (tx_q.size() != 5 || err_cnt !== 8'(m_err)) begin
      bad++;
      $display("FAIL slow_frame_reply got_n=%0d err=%0d want=5 err=%0d", tx_q.size(), err_cnt, m_err);
    end
    frm_q = '{8'h7E, NODE};
    send_bytes(0, 0);
    repeat (TIMEOUT - 1) @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early got=%b want=1", busy); end
    @(negedge clock);
    if (m_err < 255) m_err++;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_hunt got=%b want=0", busy); end
    total++;
    if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL timeout_err got=%0d want=%0d", err_cnt, m_err); end
  endtask

  task automatic test_reset_mid_reply;
    int n, sz;
    frm_q = '{8'h7E, NODE, 8'h05, 8'h02, 8'hAA, 8'h55, NODE ^ 8'h05 ^ 8'h02 ^ 8'hAA ^ 8'h55};
    tx_q.delete();
    send_bytes(0, 0);
    n = 0;
    while (tx_q.size() < 4 && n < 300) begin @(negedge clock); #1; n++; end
    total++;
    if (n >= 300) begin bad++; $display("FAIL reply_progress got=%0d want=4 bytes", tx_q.size()); end
    reset = 1'b0;
    #1;
    total++;
    if (tx_cmd !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%h want=0/0/00", tx_cmd, busy, tx_data);
    end
    total++;
    if (err_cnt !== 8'h00 || frm_cmd !== 8'h00 || frm_len !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_regs got=%h/%h/%h want=00/00/00", err_cnt, frm_cmd, frm_len);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    sz = tx_q.size();
    repeat (60) @(negedge clock);
    total++;
    if (tx_q.size() != sz || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_tx got=%0d bytes busy=%b want=%0d bytes busy=0", tx_q.size(), busy, sz);
    end
  endtask

  initial begin
    test_reset();
    test_frames(40);
    test_len_overflow();
    test_timeout();
    test_reset_mid_reply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
